com_block: RTL and testbench
============================

Name: com_block

Overview:
- Memory-mapped communication/IO peripheral attached to the processor port's 8-bit com bus.
- Provides:
  - an LED output register
  - switch/key input sampling
  - one 8N1 UART (TX and RX)
  - an interrupt controller with a single level interrupt line to the CPU.
- Runs entirely on the CPU master clock.

Parameters:
- BAUD_DIV, 104, clock cycles per UART bit (1 MHz / 104 ≈ 9600 baud); legal range is 4 or more.

Ports:
- clk  in  1  master clock; all logic on its rising edge
- rst  in  1  synchronous reset, active-high
- addr  in  8  bus address:
  - addr[7]=1 means write, addr[7]=0 means read
  - addr[6:0] is the register index
  - addr=0x00 means idle
- in_data  in  8  write data, sampled on the clock edge when addr[7]=1
- out_data  out  8  read data, combinational from addr[6:0]
- interrupt  out  1  registered level interrupt to the CPU
- leds  out  8  LED register contents
- switches  in  4  DIP switches, asynchronous
- uart0_rx  in  1  UART receive line, asynchronous, idles high
- uart0_tx  out  1  UART transmit line, idles high
- key1  in  1  push key, active-high, asynchronous

Behaviour:
- Reset values (synchronous, rst=1 at a rising clk edge):
  - leds=0x00, uart0_tx=1, interrupt=0
  - IE=0, all flags 0, RXDATA=0x00
  - TX and RX state machines go to IDLE
  - reset mid-frame aborts immediately
- Input synchronisation: uart0_rx, key1 and switches each pass through a 2-FF synchronizer before use.
- Register map (index = addr[6:0]):
  - 0x01 LED, R/W: a write loads leds from in_data; a read returns leds.
  - 0x02 INPUT, R: {3'b0, key1_sync, switches_sync[3:0]}.
  - 0x03 STATUS, R: bit0 tx_busy, bit1 rx_valid, bit2 rx_overrun, bit3 rx_frame_err, bit4 key_evt; bits 7:5 read 0.
  - 0x04 TXDATA, W: starts transmission of in_data if the transmitter is idle; the write is ignored if tx_busy=1; reads return 0x00.
  - 0x05 RXDATA, R: returns the last received byte. On each clock edge where addr=0x05, rx_valid and rx_overrun clear.
  - 0x06 IE, R/W: bit0 rx_valid enable, bit1 tx_done enable, bit2 key_evt enable; bits 7:3 read 0.
  - 0x07 FLAGS, R/W1C: bit0 rx_valid, bit1 tx_done, bit2 key_evt.
    - Writing 1 to a bit clears it.
    - rx_valid can also be cleared by reading RXDATA.
  - Other indices: reads return 0x00; writes are ignored.
- Read timing: out_data is combinational from addr in the same cycle. Read side effects are applied at the clock edge.
- Flag set vs clear: setting a flag in the same cycle as its clear makes the flag stay set (set wins).
- interrupt is registered: interrupt <= |(IE[2:0] & {key_evt, tx_done, rx_valid}). It is 1 cycle behind the flags.
- UART TX states IDLE → START → DATA → STOP → IDLE:
  - Each bit lasts BAUD_DIV cycles; data is sent LSB first.
  - uart0_tx goes low in the cycle after the accepted write.
  - tx_busy=1 from the accepting edge until STOP completes (10*BAUD_DIV cycles). tx_done sets when STOP completes.
- UART RX states IDLE → START → DATA → STOP:
  - A falling edge on the synchronized rx enters START.
  - At BAUD_DIV/2 the line is re-sampled. If high, it is a false start and the state returns to IDLE.
  - Data bits are sampled mid-bit, every BAUD_DIV cycles, LSB first.
  - Stop bit high: RXDATA is loaded and rx_valid set. If rx_valid was already 1, rx_overrun sets and the new byte overwrites.
  - Stop bit low: the byte is discarded and rx_frame_err sets. rx_frame_err clears on a read of STATUS.
- key_evt sets on a rising edge of key1_sync (no debounce).

Test Plan:
- Reset then LED write:
  - Hold rst 2 cycles → leds=0x00, uart0_tx=1, interrupt=0.
  - addr=0x81, in_data=0xA5 for 1 cycle → leds=0xA5.
  - addr=0x01 → out_data=0xA5.
- Input read: switches=4'b0110, key1=0, wait 3 cycles; addr=0x02 → out_data=0x06. Set key1=1 and wait 3 cycles → out_data=0x16.
- UART TX with BAUD_DIV=8:
  - Write 0x84 with in_data=0x55; uart0_tx shows start 0, then 1,0,1,0,1,0,1,0, then stop 1, each bit 8 cycles.
  - STATUS bit0=1 throughout. A second write of 0xAA mid-frame is ignored.
  - After completion, FLAGS bit1=1.
- UART RX with BAUD_DIV=8:
  - Drive the frame for 0xA3 → STATUS bit1=1; addr=0x05 reads 0xA3, then STATUS bit1=0.
  - Send 2 bytes without reading → rx_overrun=1 and RXDATA holds the second byte.
  - A frame with stop=0 → rx_valid stays 0 and rx_frame_err=1.
- Interrupt:
  - Write 0x86 with 0x04, then pulse key1 → interrupt=1 within 4 cycles.
  - Write 0x87 with 0x04 → interrupt=0 one cycle later.
- Reset mid-TX: assert rst during the DATA state → uart0_tx=1 and STATUS=0x00 the next cycle.

Source files
------------

// File: rtl/com_block.sv
`default_nettype none
// ============================================================================
// Module : com_block
// Brief  : Bus-mapped IO peripheral: LEDs, switch/key input, 8N1 UART, IRQ.
// Rev    : 1.0
// ============================================================================
module com_block #(
    parameter int BAUD_DIV = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] addr,
    input  logic [7:0] in_data,
    output logic [7:0] out_data,
    output logic       interrupt,
    output logic [7:0] leds,
    input  logic [3:0] switches,
    input  logic       uart0_rx,
    output logic       uart0_tx,
    input  logic       key1
);
    localparam int c_cnt_w = $clog2(BAUD_DIV);
    localparam logic [c_cnt_w-1:0] c_last    = c_cnt_w'(BAUD_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_half_m1 = c_cnt_w'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    logic       r_rx_s1, r_rx_s2, r_rx_prev;
    logic       r_key_s1, r_key_s2, r_key_prev;
    logic [3:0] r_sw_s1, r_sw_s2;
    logic [7:0] r_leds, r_rxdata;
    logic [2:0] r_ie;
    logic       r_rx_valid, r_tx_done, r_key_evt, r_rx_overrun, r_rx_frame_err;
    logic       r_irq;

    // Bus decode
    logic [6:0] w_idx;
    logic       w_wr_led, w_wr_tx, w_wr_ie, w_wr_flags, w_rd_rxdata, w_rd_status;
    assign w_idx       = addr[6:0];
    assign w_wr_led    = addr[7] && (w_idx == 7'h01);
    assign w_wr_tx     = addr[7] && (w_idx == 7'h04);
    assign w_wr_ie     = addr[7] && (w_idx == 7'h06);
    assign w_wr_flags  = addr[7] && (w_idx == 7'h07);
    assign w_rd_rxdata = (addr == 8'h05);
    assign w_rd_status = (addr == 8'h03);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_s1 <= 1'b1; r_rx_s2 <= 1'b1; r_rx_prev <= 1'b1;
            r_key_s1 <= 1'b0; r_key_s2 <= 1'b0; r_key_prev <= 1'b0;
            r_sw_s1 <= 4'h0; r_sw_s2 <= 4'h0;
        end else begin
            r_rx_s1 <= uart0_rx; r_rx_s2 <= r_rx_s1; r_rx_prev <= r_rx_s2;
            r_key_s1 <= key1; r_key_s2 <= r_key_s1; r_key_prev <= r_key_s2;
            r_sw_s1 <= switches; r_sw_s2 <= r_sw_s1;
        end
    end

    // ---------------- Transmitter ----------------
    uart_state_t        r_tx_state, w_tx_next;
    logic [c_cnt_w-1:0] r_tx_cnt;
    logic [2:0]         r_tx_bit;
    logic [7:0]         r_tx_sh;
    logic               r_tx_line, w_tx_line_next, w_tx_done_set, w_tx_bit_end, w_tx_busy;

    assign w_tx_bit_end = (r_tx_cnt == c_last);
    assign w_tx_busy    = (r_tx_state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= ST_IDLE;
            r_tx_line  <= 1'b1;
        end else begin
            r_tx_state <= w_tx_next;
            r_tx_line  <= w_tx_line_next;
        end
    end

    always_comb begin
        w_tx_next      = r_tx_state;
        w_tx_done_set  = 1'b0;
        w_tx_line_next = 1'b1;
        case (r_tx_state)
            ST_IDLE:  if (w_wr_tx) w_tx_next = ST_START;
            ST_START: if (w_tx_bit_end) w_tx_next = ST_DATA;
            ST_DATA:  if (w_tx_bit_end && (r_tx_bit == 3'd7)) w_tx_next = ST_STOP;
            ST_STOP: begin
                if (w_tx_bit_end) begin
                    w_tx_next     = ST_IDLE;
                    w_tx_done_set = 1'b1;
                end
            end
            default:  w_tx_next = ST_IDLE;
        endcase
        // Line is registered from the next state so it never glitches.
        case (w_tx_next)
            ST_START: w_tx_line_next = 1'b0;
            ST_DATA:  w_tx_line_next = ((r_tx_state == ST_DATA) && w_tx_bit_end) ? r_tx_sh[1] : r_tx_sh[0];
            default:  w_tx_line_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_cnt <= '0;
            r_tx_bit <= 3'd0;
            r_tx_sh  <= 8'h00;
        end else if (r_tx_state == ST_IDLE) begin
            r_tx_cnt <= '0;
            r_tx_bit <= 3'd0;
            if (w_wr_tx) r_tx_sh <= in_data;
        end else begin
            r_tx_cnt <= w_tx_bit_end ? '0 : r_tx_cnt + 1'b1;
            if (w_tx_bit_end && (r_tx_state == ST_DATA)) begin
                r_tx_sh  <= {1'b0, r_tx_sh[7:1]};
                r_tx_bit <= r_tx_bit + 3'd1;
            end
        end
    end

    // ---------------- Receiver ----------------
    uart_state_t        r_rx_state, w_rx_next;
    logic [c_cnt_w-1:0] r_rx_cnt;
    logic [2:0]         r_rx_bit;
    logic [7:0]         r_rx_sh;
    logic               w_rx_load, w_rx_ferr, w_rx_bit_end;

    assign w_rx_bit_end = (r_rx_cnt == c_last);

    always_ff @(posedge clk) begin
        if (rst) r_rx_state <= ST_IDLE;
        else     r_rx_state <= w_rx_next;
    end

    always_comb begin
        w_rx_next = r_rx_state;
        w_rx_load = 1'b0;
        w_rx_ferr = 1'b0;
        case (r_rx_state)
            ST_IDLE:  if (r_rx_prev && !r_rx_s2) w_rx_next = ST_START;
            ST_START: if (r_rx_cnt == c_half_m1) w_rx_next = r_rx_s2 ? ST_IDLE : ST_DATA;
            ST_DATA:  if (w_rx_bit_end && (r_rx_bit == 3'd7)) w_rx_next = ST_STOP;
            ST_STOP: begin
                if (w_rx_bit_end) begin
                    w_rx_next = ST_IDLE;
                    w_rx_load = r_rx_s2;
                    w_rx_ferr = !r_rx_s2;
                end
            end
            default:  w_rx_next = ST_IDLE;
        endcase
    end

    // The counter restarts on every state change, so after the half-bit
    // alignment in START each later sample lands mid-bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_cnt <= '0;
            r_rx_bit <= 3'd0;
            r_rx_sh  <= 8'h00;
        end else begin
            if ((r_rx_state == ST_IDLE) || (w_rx_next != r_rx_state) || w_rx_bit_end)
                r_rx_cnt <= '0;
            else
                r_rx_cnt <= r_rx_cnt + 1'b1;
            if (r_rx_state == ST_IDLE) begin
                r_rx_bit <= 3'd0;
            end else if ((r_rx_state == ST_DATA) && w_rx_bit_end) begin
                r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
                r_rx_bit <= r_rx_bit + 3'd1;
            end
        end
    end

    // ---------------- Registers and flags (set wins over clear) ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_leds <= 8'h00; r_ie <= 3'b000; r_rxdata <= 8'h00;
            r_rx_valid <= 1'b0; r_tx_done <= 1'b0; r_key_evt <= 1'b0;
            r_rx_overrun <= 1'b0; r_rx_frame_err <= 1'b0; r_irq <= 1'b0;
        end else begin
            if (w_wr_led) r_leds <= in_data;
            if (w_wr_ie)  r_ie   <= in_data[2:0];
            if (w_rx_load) r_rxdata <= r_rx_sh;

            if (w_rx_load) r_rx_valid <= 1'b1;
            else if (w_rd_rxdata || (w_wr_flags && in_data[0])) r_rx_valid <= 1'b0;

            if (w_rx_load && r_rx_valid) r_rx_overrun <= 1'b1;
            else if (w_rd_rxdata) r_rx_overrun <= 1'b0;

            if (w_rx_ferr) r_rx_frame_err <= 1'b1;
            else if (w_rd_status) r_rx_frame_err <= 1'b0;

            if (w_tx_done_set) r_tx_done <= 1'b1;
            else if (w_wr_flags && in_data[1]) r_tx_done <= 1'b0;

            if (r_key_s2 && !r_key_prev) r_key_evt <= 1'b1;
            else if (w_wr_flags && in_data[2]) r_key_evt <= 1'b0;

            r_irq <= |(r_ie & {r_key_evt, r_tx_done, r_rx_valid});
        end
    end

    always_comb begin
        out_data = 8'h00;
        case (w_idx)
            7'h01:   out_data = r_leds;
            7'h02:   out_data = {3'b000, r_key_s2, r_sw_s2};
            7'h03:   out_data = {3'b000, r_key_evt, r_rx_frame_err, r_rx_overrun, r_rx_valid, w_tx_busy};
            7'h05:   out_data = r_rxdata;
            7'h06:   out_data = {5'b00000, r_ie};
            7'h07:   out_data = {5'b00000, r_key_evt, r_tx_done, r_rx_valid};
            default: out_data = 8'h00;
        endcase
    end

    assign leds      = r_leds;
    assign uart0_tx  = r_tx_line;
    assign interrupt = r_irq;
endmodule
`default_nettype wire

// File: tb/tb_com_block.sv
`default_nettype none
// ============================================================================
// Module : tb_com_block
// Brief  : Randomised self-checking bench for com_block against a flag model.
// Rev    : 1.0
// ============================================================================
module tb_com_block;
    localparam int BAUD = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] addr, in_data, out_data, leds;
    logic       interrupt, uart0_tx, uart0_rx, key1;
    logic [3:0] switches;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the peripheral's visible state in plain variables
    logic [7:0] m_leds, m_rxdata;
    logic       m_rx_valid, m_tx_done, m_key_evt, m_ovr, m_ferr, m_key_line;

    com_block #(.BAUD_DIV(BAUD)) dut (
        .clk(clk), .rst(rst), .addr(addr), .in_data(in_data), .out_data(out_data),
        .interrupt(interrupt), .leds(leds), .switches(switches),
        .uart0_rx(uart0_rx), .uart0_tx(uart0_tx), .key1(key1)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (got timeout, need $finish)");
        $fatal(1);
    end

    function automatic logic [7:0] exp_status();
        return {3'b000, m_key_evt, m_ferr, m_ovr, m_rx_valid, 1'b0};
    endfunction

    function automatic logic [7:0] exp_flags();
        return {5'b00000, m_key_evt, m_tx_done, m_rx_valid};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [6:0] idx, input logic [7:0] d);
        addr = {1'b1, idx}; in_data = d;
        tick();
        addr = 8'h00; in_data = 8'h00;
    endtask

    task automatic bus_read(input logic [6:0] idx, output logic [7:0] v);
        addr = {1'b0, idx};
        #1 v = out_data;
        tick();
        addr = 8'h00;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int k = 0; k < 10; k++) begin
            uart0_rx = f[k];
            repeat (BAUD) tick();
        end
        uart0_rx = 1'b1;
        repeat (4) tick();
        if (stop) begin
            if (m_rx_valid) m_ovr = 1'b1;
            m_rxdata   = d;
            m_rx_valid = 1'b1;
        end else begin
            m_ferr = 1'b1;
        end
    endtask

    task automatic test_reset();
        logic [7:0] v;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        n_vec++; if (leds !== 8'h00) begin n_err++; $display("FAIL reset_leds got %h need 00", leds); end
        n_vec++; if (uart0_tx !== 1'b1) begin n_err++; $display("FAIL reset_tx got %b need 1", uart0_tx); end
        n_vec++; if (interrupt !== 1'b0) begin n_err++; $display("FAIL reset_irq got %b need 0", interrupt); end
        bus_read(7'h03, v);
        n_vec++; if (v !== 8'h00) begin n_err++; $display("FAIL reset_status got %h need 00", v); end
    endtask

    task automatic test_led();
        logic [7:0] v, d;
        for (int i = 0; i < 5; i++) begin
            d = (i == 0) ? 8'hA5 : 8'($urandom);
            bus_write(7'h01, d);
            m_leds = d;
            n_vec++; if (leds !== m_leds) begin n_err++; $display("FAIL led_port got %h need %h", leds, m_leds); end
            bus_read(7'h01, v);
            n_vec++; if (v !== m_leds) begin n_err++; $display("FAIL led_read got %h need %h", v, m_leds); end
        end
        d = 8'($urandom);
        bus_write(7'h06, d);
        bus_read(7'h06, v);
        n_vec++; if (v !== {5'b0, d[2:0]}) begin n_err++; $display("FAIL ie_read got %h need %h", v, {5'b0, d[2:0]}); end
        bus_write(7'h06, 8'h00);
    endtask

    task automatic test_input();
        logic [7:0] v;
        logic [3:0] sw;
        logic       k;
        for (int i = 0; i < 6; i++) begin
            sw = (i < 2) ? 4'b0110 : 4'($urandom);
            k  = (i < 2) ? i[0] : 1'($urandom);
            switches = sw; key1 = k;
            if (k && !m_key_line) m_key_evt = 1'b1;
            m_key_line = k;
            repeat (3) tick();
            bus_read(7'h02, v);
            n_vec++; if (v !== {3'b000, k, sw}) begin n_err++; $display("FAIL input_read got %h need %h", v, {3'b000, k, sw}); end
        end
        bus_read(7'h03, v);
        n_vec++; if (v !== exp_status()) begin n_err++; $display("FAIL input_status got %h need %h", v, exp_status()); end
        key1 = 1'b0; m_key_line = 1'b0;
        repeat (3) tick();
        bus_write(7'h07, 8'h07);
        m_key_evt = 1'b0; m_tx_done = 1'b0; m_rx_valid = 1'b0;
        bus_read(7'h07, v);
        n_vec++; if (v !== exp_flags()) begin n_err++; $display("FAIL flags_clear got %h need %h", v, exp_flags()); end
    endtask

    task automatic test_unmapped();
        logic [7:0] v;
        logic [6:0] idx;
        bus_read(7'h04, v);
        n_vec++; if (v !== 8'h00) begin n_err++; $display("FAIL txdata_read got %h need 00", v); end
        for (int i = 0; i < 3; i++) begin
            idx = 7'($urandom_range(8, 127));
            bus_write(idx, 8'($urandom));
            bus_read(idx, v);
            n_vec++; if (v !== 8'h00) begin n_err++; $display("FAIL unmapped_read idx %h got %h need 00", idx, v); end
        end
        n_vec++; if (leds !== m_leds) begin n_err++; $display("FAIL unmapped_leds got %h need %h", leds, m_leds); end
    endtask

    task automatic test_tx(input logic [7:0] d);
        logic [9:0] f;
        logic [7:0] v;
        f = {1'b1, d, 1'b0};
        bus_write(7'h04, d);
        for (int i = 0; i < 10 * BAUD; i++) begin
            if (i == 44) begin
                addr = 8'h84; in_data = 8'hAA;
            end else begin
                addr = 8'h03;
            end
            #1;
            n_vec++; if (uart0_tx !== f[i / BAUD]) begin n_err++; $display("FAIL tx_bit cycle %0d got %b need %b", i, uart0_tx, f[i / BAUD]); end
            if (i != 44) begin
                n_vec++; if (out_data[0] !== 1'b1) begin n_err++; $display("FAIL tx_busy cycle %0d got %b need 1", i, out_data[0]); end
            end
            tick();
        end
        addr = 8'h00; in_data = 8'h00;
        m_ferr = 1'b0;
        m_tx_done = 1'b1;
        n_vec++; if (uart0_tx !== 1'b1) begin n_err++; $display("FAIL tx_idle got %b need 1", uart0_tx); end
        bus_read(7'h07, v);
        n_vec++; if (v !== exp_flags()) begin n_err++; $display("FAIL tx_done_flag got %h need %h", v, exp_flags()); end
        bus_read(7'h03, v);
        n_vec++; if (v !== exp_status()) begin n_err++; $display("FAIL tx_status_after got %h need %h", v, exp_status()); end
        bus_write(7'h07, 8'h02);
        m_tx_done = 1'b0;
    endtask

    task automatic test_rx();
        logic [7:0] v, d;
        for (int i = 0; i < 3; i++) begin
            d = (i == 0) ? 8'hA3 : 8'($urandom);
            send_frame(d, 1'b1);
            bus_read(7'h03, v);
            m_ferr = 1'b0;
            n_vec++; if (v !== exp_status()) begin n_err++; $display("FAIL rx_status got %h need %h", v, exp_status()); end
            bus_read(7'h05, v);
            n_vec++; if (v !== m_rxdata) begin n_err++; $display("FAIL rx_data got %h need %h", v, m_rxdata); end
            m_rx_valid = 1'b0; m_ovr = 1'b0;
            bus_read(7'h03, v);
            n_vec++; if (v !== exp_status()) begin n_err++; $display("FAIL rx_status_clr got %h need %h", v, exp_status()); end
        end
    endtask

    task automatic test_overrun();
        logic [7:0] v;
        send_frame(8'($urandom), 1'b1);
        send_frame(8'($urandom), 1'b1);
        bus_read(7'h03, v);
        m_ferr = 1'b0;
        n_vec++; if (v !== exp_status()) begin n_err++; $display("FAIL ovr_status got %h need %h", v, exp_status()); end
        bus_read(7'h05, v);
        n_vec++; if (v !== m_rxdata) begin n_err++; $display("FAIL ovr_data got %h need %h", v, m_rxdata); end
        m_rx_valid = 1'b0; m_ovr = 1'b0;
        bus_read(7'h03, v);
        n_vec++; if (v !== exp_status()) begin n_err++; $display("FAIL ovr_clear got %h need %h", v, exp_status()); end
    endtask

    task automatic test_frame_err();
        logic [7:0] v;
        send_frame(8'($urandom), 1'b0);
        bus_read(7'h03, v);
        n_vec++; if (v !== exp_status()) begin n_err++; $display("FAIL ferr_status got %h need %h", v, exp_status()); end
        m_ferr = 1'b0;
        bus_read(7'h03, v);
        n_vec++; if (v !== exp_status()) begin n_err++; $display("FAIL ferr_clear got %h need %h", v, exp_status()); end
    endtask

    task automatic test_interrupt();
        logic [7:0] v;
        bit         seen;
        bus_write(7'h06, 8'h04);
        key1 = 1'b1;
        tick();
        key1 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            tick();
            if (interrupt === 1'b1) seen = 1'b1;
        end
        m_key_evt = 1'b1;
        n_vec++; if (!seen) begin n_err++; $display("FAIL irq_key got %b need 1 within 4 cycles", interrupt); end
        bus_write(7'h07, 8'h04);
        m_key_evt = 1'b0;
        n_vec++; if (interrupt !== 1'b1) begin n_err++; $display("FAIL irq_lag got %b need 1", interrupt); end
        tick();
        n_vec++; if (interrupt !== 1'b0) begin n_err++; $display("FAIL irq_clear got %b need 0", interrupt); end

        bus_write(7'h06, 8'h01);
        send_frame(8'($urandom), 1'b1);
        n_vec++; if (interrupt !== 1'b1) begin n_err++; $display("FAIL irq_rx got %b need 1", interrupt); end
        bus_read(7'h05, v);
        n_vec++; if (v !== m_rxdata) begin n_err++; $display("FAIL irq_rx_data got %h need %h", v, m_rxdata); end
        m_rx_valid = 1'b0; m_ovr = 1'b0;
        tick();
        n_vec++; if (interrupt !== 1'b0) begin n_err++; $display("FAIL irq_rx_clear got %b need 0", interrupt); end
        bus_write(7'h06, 8'h00);
    endtask

    task automatic test_reset_mid_tx();
        bit stuck;
        bus_write(7'h04, 8'($urandom) & 8'hFE);
        repeat (3 * BAUD + 2) tick();
        rst = 1'b1;
        tick();
        addr = 8'h03;
        #1;
        n_vec++; if (uart0_tx !== 1'b1) begin n_err++; $display("FAIL rst_tx got %b need 1", uart0_tx); end
        n_vec++; if (out_data !== 8'h00) begin n_err++; $display("FAIL rst_status got %h need 00", out_data); end
        n_vec++; if (leds !== 8'h00) begin n_err++; $display("FAIL rst_leds got %h need 00", leds); end
        rst = 1'b0;
        addr = 8'h00;
        m_leds = 8'h00;
        stuck = 1'b0;
        for (int i = 0; i < 10 * BAUD; i++) begin
            tick();
            if (uart0_tx !== 1'b1) stuck = 1'b1;
        end
        n_vec++; if (stuck) begin n_err++; $display("FAIL rst_tx_quiet got 0 need 1 for whole frame"); end
    endtask

    initial begin
        rst = 1'b1; addr = 8'h00; in_data = 8'h00;
        switches = 4'h0; uart0_rx = 1'b1; key1 = 1'b0;
        m_leds = 8'h00; m_rxdata = 8'h00;
        m_rx_valid = 1'b0; m_tx_done = 1'b0; m_key_evt = 1'b0;
        m_ovr = 1'b0; m_ferr = 1'b0; m_key_line = 1'b0;

        test_reset();
        test_led();
        test_input();
        test_unmapped();
        test_tx(8'h55);
        test_tx(8'($urandom));
        test_rx();
        test_overrun();
        test_frame_err();
        test_interrupt();
        test_reset_mid_tx();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
